frame_reg_bank: RTL and testbench

FRAME_REG_BANK -- requirements
Module: frame_reg_bank

---
 rtl/frame_reg_bank.sv | 122 ++++++++++++
 tb/tb_frame_reg_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_reg_bank.sv
// Frame register bank: column-masked parallel writes, full-frame parallel view,
// and a row- or column-major serial readout stream with ready/valid handshake.

module frame_reg_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_en,
    input  logic             ld_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst || clr_en) q <= '0;
        else if (ld_en)    q <= d;
    end
endmodule

module frame_reg_bank #(
    parameter int WIDTH = 32,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    localparam int N    = ROWS * COLS,
    localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [COLS-1:0]      wr_col_mask,
    input  logic [N*WIDTH-1:0]   wr_data,
    input  logic                 clr,
    output logic [N*WIDTH-1:0]   frame_out,
    input  logic                 rd_start,
    input  logic                 rd_col_major,
    output logic                 rd_busy,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [WIDTH-1:0]     rd_data,
    output logic [IW-1:0]        rd_index,
    output logic                 rd_last
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state, state_nxt;
    logic [IW-1:0]           k, k_nxt;
    logic                    col_major, col_major_nxt;
    logic [N-1:0][WIDTH-1:0] store;
    logic                    wr_acc, clr_en, streaming, at_last;
    logic [IW-1:0]           rd_idx;

    assign streaming = (state == STREAM);
    assign wr_ready  = (state == IDLE) && !rst;
    assign wr_acc    = wr_valid && wr_ready;
    // Clear shares the cell's reset path, so it wins over a same-cycle write.
    assign clr_en    = clr && (state == IDLE);

    for (genvar i = 0; i < N; i++) begin : g_cell
        frame_reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk    (clk),
            .rst    (rst),
            .clr_en (clr_en),
            .ld_en  (wr_acc && wr_col_mask[i % COLS]),
            .d      (wr_data[i*WIDTH +: WIDTH]),
            .q      (store[i])
        );
    end

    assign frame_out = store;

    always_comb begin
        rd_idx = k;
        if (col_major)
            rd_idx = IW'((int'(k) % ROWS) * COLS + int'(k) / ROWS);
    end

    assign at_last  = streaming && (k == IW'(N - 1));
    assign rd_valid = streaming;
    assign rd_busy  = streaming;
    assign rd_last  = at_last;
    assign rd_index = streaming ? rd_idx : '0;
    assign rd_data  = streaming ? store[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            col_major <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            col_major <= col_major_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        col_major_nxt = col_major;
        case (state)
            IDLE: begin
                if (rd_start) begin
                    state_nxt     = STREAM;
                    k_nxt         = '0;
                    col_major_nxt = rd_col_major;
                end
            end
            STREAM: begin
                if (rd_ready) begin
                    if (at_last) begin
                        state_nxt = IDLE;
                        k_nxt     = '0;
                    end else begin
                        k_nxt = k + IW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_frame_reg_bank.sv
// Bench for frame_reg_bank: directed scenarios plus random traffic, all checked
// each cycle against a queue/array reference model of the frame and stream.

module tb_frame_reg_bank;
    localparam int W = 32, R = 4, C = 4, N = R * C, IW = 4;

    logic             clk, rst, wr_valid, wr_ready, clr;
    logic [C-1:0]     wr_col_mask;
    logic [N*W-1:0]   wr_data, frame_out;
    logic             rd_start, rd_col_major, rd_busy, rd_valid, rd_ready, rd_last;
    logic [W-1:0]     rd_data;
    logic [IW-1:0]    rd_index;

    frame_reg_bank #(.WIDTH(W), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_col_mask(wr_col_mask), .wr_data(wr_data), .clr(clr),
        .frame_out(frame_out), .rd_start(rd_start), .rd_col_major(rd_col_major),
        .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_index(rd_index), .rd_last(rd_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0, n_fail = 0;
    logic [W-1:0] mem [N];
    bit          m_stream;
    int          q [$];

    task automatic check(string tag, logic [N*W-1:0] obs, logic [N*W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] packed_mem();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = mem[i];
        return v;
    endfunction

    // Reference update at the clock edge, using the inputs held across it.
    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < N; i++) mem[i] = '0;
            m_stream = 0;
            q.delete();
        end else if (!m_stream) begin
            if (clr)
                for (int i = 0; i < N; i++) mem[i] = '0;
            else if (wr_valid)
                for (int r = 0; r < R; r++)
                    for (int c = 0; c < C; c++)
                        if (wr_col_mask[c]) mem[r*C+c] = wr_data[(r*C+c)*W +: W];
            if (rd_start) begin
                m_stream = 1;
                q.delete();
                if (rd_col_major)
                    for (int c = 0; c < C; c++) for (int r = 0; r < R; r++) q.push_back(r*C+c);
                else
                    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) q.push_back(r*C+c);
            end
        end else if (rd_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) m_stream = 0;
        end
    endtask

    task automatic compare_all();
        check("frame_out", frame_out, packed_mem());
        check("wr_ready",  wr_ready,  (!m_stream && !rst));
        check("rd_valid",  rd_valid,  m_stream);
        check("rd_busy",   rd_busy,   m_stream);
        check("rd_index",  rd_index,  m_stream ? q[0] : 0);
        check("rd_data",   rd_data,   m_stream ? mem[q[0]] : '0);
        check("rd_last",   rd_last,   (m_stream && q.size() == 1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        int exp_col [N];
        int j;
        logic [IW-1:0] held_idx;
        logic [W-1:0]  held_data;
        logic [N*W-1:0] frame_snap;

        rst = 1; wr_valid = 0; wr_col_mask = '0; wr_data = '0; clr = 0;
        rd_start = 0; rd_col_major = 0; rd_ready = 0;
        m_stream = 0;
        for (int i = 0; i < N; i++) mem[i] = '0;

        // Reset
        tick(); tick();
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_frame", frame_out, '0);
        rst = 0;
        #1;
        check("post_rst_wr_ready", wr_ready, 1'b1);

        // Masked write, columns 0-2
        for (int i = 0; i < N; i++) wr_data[i*W +: W] = 32'h100 + i;
        wr_col_mask = 4'b0111; wr_valid = 1;
        tick();
        check("w1_e0", frame_out[0*W +: W], 32'h100);
        check("w1_e3", frame_out[3*W +: W], 32'h0);
        check("w1_e14", frame_out[14*W +: W], 32'h10E);

        // Column 3 only
        for (int i = 0; i < N; i++) wr_data[i*W +: W] = 32'hA00 + i;
        wr_col_mask = 4'b1000;
        tick();
        wr_valid = 0;
        check("w2_e3", frame_out[3*W +: W], 32'hA03);
        check("w2_e15", frame_out[15*W +: W], 32'hA0F);
        check("w2_e5", frame_out[5*W +: W], 32'h105);

        // Row-major stream at full rate
        rd_start = 1; rd_col_major = 0; rd_ready = 1;
        tick();
        rd_start = 0;
        for (int i = 0; i < N; i++) begin
            check("rm_index", rd_index, i);
            check("rm_last", rd_last, (i == N - 1));
            tick();
        end
        check("rm_busy_after", rd_busy, 1'b0);

        // Column-major stream with toggling ready and a blocked write
        rd_start = 1; rd_col_major = 1; rd_ready = 0;
        tick();
        rd_start = 0;
        wr_valid = 1; wr_col_mask = 4'hF;
        for (int i = 0; i < N; i++) wr_data[i*W +: W] = $urandom;
        for (int i = 0; i < N; i++) exp_col[i] = (i % R) * C + i / R;
        frame_snap = frame_out;
        j = 0;
        for (int t = 0; t < 4 * N && m_stream; t++) begin
            rd_ready = t[0];
            if (rd_ready) begin
                check("cm_index", rd_index, exp_col[j]);
                j++;
            end else begin
                held_idx = rd_index; held_data = rd_data;
            end
            tick();
            if (!rd_ready && m_stream) begin
                check("cm_hold_idx", rd_index, held_idx);
                check("cm_hold_data", rd_data, held_data);
            end
        end
        check("cm_beats", j, N);
        check("cm_frame_unchanged", frame_out, frame_snap);
        wr_valid = 0;

        // rd_start + write + clr in one cycle: clear wins, stream shows zeros
        for (int i = 0; i < N; i++) wr_data[i*W +: W] = 32'h55;
        wr_valid = 1; clr = 1; rd_start = 1; rd_col_major = 0; rd_ready = 1;
        tick();
        wr_valid = 0; clr = 0; rd_start = 0;
        check("clr_frame", frame_out, '0);
        for (int i = 0; i < N; i++) begin
            check("clr_stream_zero", rd_data, 32'h0);
            tick();
        end

        // Random traffic
        for (int t = 0; t < 600; t++) begin
            rst          = ($urandom_range(0, 79) == 0);
            clr          = ($urandom_range(0, 11) == 0);
            wr_valid     = $urandom_range(0, 1);
            wr_col_mask  = C'($urandom);
            for (int i = 0; i < N; i++) wr_data[i*W +: W] = $urandom;
            rd_start     = ($urandom_range(0, 5) == 0);
            rd_col_major = $urandom_range(0, 1);
            rd_ready     = $urandom_range(0, 1);
            tick();
        end
        rst = 0; clr = 0; wr_valid = 0; rd_start = 0; rd_ready = 1;
        for (int t = 0; t < 2 * N && m_stream; t++) tick();
        check("drain_idle", rd_busy, 1'b0);

        // Reset mid-stream at k=6
        for (int i = 0; i < N; i++) wr_data[i*W +: W] = 32'hC0 + i;
        wr_valid = 1; wr_col_mask = 4'hF;
        tick();
        wr_valid = 0; rd_start = 1; rd_col_major = 1;
        tick();
        rd_start = 0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_index", rd_index, 4'd9);
        rst = 1;
        tick();
        check("mid_rst_valid", rd_valid, 1'b0);
        check("mid_rst_frame", frame_out, '0);
        rst = 0;
        tick();
        check("mid_rst_wr_ready", wr_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
